sonar_echo_responder: RTL and testbench



---
 rtl/sonar_echo_responder.sv | 148 ++++++++++++++
 tb/tb_sonar_echo_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_echo_responder.sv
// HC-SR04 style echo responder: trigger in, distance-coded echo out.
// Define SONAR_JITTER_EN to add LFSR-based jitter to the echo width.
module sonar_echo_responder #(
    parameter int unsigned CYC_PER_CM      = 5800,
    parameter int unsigned MIN_TRIG_CYCLES = 1000,
    parameter int unsigned HOLDOFF_CYCLES  = 20000,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYCLES  = 3800000,
    parameter int unsigned GUARD_CYCLES    = 6000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [15:0] distance_cm,
    input  logic        target_valid,
    output logic        echo,
    output logic        busy,
    output logic        trig_err,
    output logic        trig_ignored
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        HOLDOFF,
        ECHO,
        GUARD
    } state_t;

    localparam logic [31:0] CYC_W     = 32'(CYC_PER_CM);
    localparam logic [31:0] MIN_W     = 32'(MIN_TRIG_CYCLES);
    localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
    localparam logic [31:0] MAX_W     = 32'(MAX_CM);
    localparam logic [31:0] TMO_W     = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] GRD_LAST  = 32'(GUARD_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        trig_m;
    logic        trig_s;
    logic        trig_q;
    logic        rise;
    logic        fall;
    logic        hi_ok;
    logic        latch;
    logic        in_run;
    logic [31:0] hi_cnt;
    logic [31:0] cnt;
    logic [31:0] width;
    logic [31:0] width_base;
    logic [31:0] width_calc;
    logic [31:0] dist_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
            trig_q <= trig_s;
        end
    end

    assign rise   = trig_s & ~trig_q;
    assign fall   = ~trig_s & trig_q;
    assign hi_ok  = (hi_cnt >= MIN_W);
    assign latch  = (state == TRIG_HI) && fall && hi_ok;
    assign in_run = (state == HOLDOFF) || (state == ECHO) || (state == GUARD);
    assign dist_w = {16'd0, distance_cm};

    // Out-of-range beats zero distance; zero reads back as 1 cm.
    always_comb begin
        width_base = dist_w * CYC_W;
        if (!target_valid || (dist_w > MAX_W)) begin
            width_base = TMO_W;
        end else if (distance_cm == 16'd0) begin
            width_base = CYC_W;
        end
    end

`ifdef SONAR_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (latch) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign width_calc = width_base + {24'd0, lfsr[7:0]};
`else
    assign width_calc = width_base;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rise) state_nxt = TRIG_HI;
            TRIG_HI: if (fall) state_nxt = hi_ok ? HOLDOFF : IDLE;
            HOLDOFF: if (cnt == HOLD_LAST) state_nxt = ECHO;
            ECHO:    if (cnt == width - 32'd1) state_nxt = GUARD;
            GUARD:   if (cnt == GRD_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt <= '0;
            cnt    <= '0;
            width  <= '0;
        end else begin
            if (state == IDLE) begin
                hi_cnt <= rise ? 32'd1 : 32'd0;
            end else if ((state == TRIG_HI) && trig_s && !hi_ok) begin
                hi_cnt <= hi_cnt + 32'd1;
            end
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (in_run) begin
                cnt <= cnt + 32'd1;
            end
            if (latch) begin
                width <= width_calc;
            end
        end
    end

    always_comb begin
        echo         = (state == ECHO);
        busy         = in_run;
        trig_err     = (state == TRIG_HI) && fall && !hi_ok;
        trig_ignored = in_run && rise;
    end

endmodule

// File: tb/tb_sonar_echo_responder.sv
// Bench for sonar_echo_responder with small timing parameters.
// Expected echo widths go through a scoreboard queue.
module tb_sonar_echo_responder;

    localparam int CPC  = 10;
    localparam int MINT = 5;
    localparam int HOLD = 4;
    localparam int MAXC = 8;
    localparam int TMO  = 100;
    localparam int GRD  = 20;
    localparam int LAT  = HOLD + 3;

    logic        clk;
    logic        rst_n;
    logic        trigger;
    logic [15:0] distance_cm;
    logic        target_valid;
    logic        echo;
    logic        busy;
    logic        trig_err;
    logic        trig_ignored;

    int n_cmp;
    int n_err;
    int ign_cnt;
    int err_cnt;
    int exp_q[$];

    sonar_echo_responder #(
        .CYC_PER_CM(CPC),
        .MIN_TRIG_CYCLES(MINT),
        .HOLDOFF_CYCLES(HOLD),
        .MAX_CM(MAXC),
        .TIMEOUT_CYCLES(TMO),
        .GUARD_CYCLES(GRD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trigger(trigger),
        .distance_cm(distance_cm),
        .target_valid(target_valid),
        .echo(echo),
        .busy(busy),
        .trig_err(trig_err),
        .trig_ignored(trig_ignored)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trig_ignored) ign_cnt++;
        if (trig_err) err_cnt++;
    end

    task automatic pulse_trig(input int n);
        trigger = 1'b1;
        repeat (n) @(negedge clk);
        trigger = 1'b0;
    endtask

    // Called right after trigger goes low; sample t is the t-th negedge.
    task automatic measure(output int lat, output int wid,
                           output int grd, output logic [1:0] bz);
        int t;
        lat = -1;
        wid = 0;
        grd = 0;
        bz  = 2'b00;
        t   = 0;
        while (t < 400) begin
            @(negedge clk);
            t++;
            if (t == 2) bz[1] = busy;
            if (t == 3) bz[0] = busy;
            if (echo) begin
                if (lat < 0) lat = t;
                wid++;
            end else if (lat >= 0) begin
                if (busy) grd++;
                else break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        trigger      = 1'b0;
        distance_cm  = 16'd0;
        target_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (echo !== 1'b0) begin
            n_err++;
            $display("FAIL rst_echo got=%b want=0", echo);
        end
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_busy got=%b want=0", busy);
        end
        if (trig_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_err got=%b want=0", trig_err);
        end
        if (trig_ignored !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ign got=%b want=0", trig_ignored);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal;
        int lat, wid, grd, exp;
        logic [1:0] bz;
        distance_cm  = 16'd3;
        target_valid = 1'b1;
        exp_q.push_back(3 * CPC);
        pulse_trig(6);
        measure(lat, wid, grd, bz);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp += 6;
        if (wid !== exp) begin
            n_err++;
            $display("FAIL nom_width got=%0d want=%0d", wid, exp);
        end
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL nom_latency got=%0d want=%0d", lat, LAT);
        end
        if (grd !== GRD) begin
            n_err++;
            $display("FAIL nom_guard got=%0d want=%0d", grd, GRD);
        end
        if (bz !== 2'b01) begin
            n_err++;
            $display("FAIL nom_busy_hold got=%b want=01", bz);
        end
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL nom_busy_end got=%b want=0", busy);
        end
        if (echo !== 1'b0) begin
            n_err++;
            $display("FAIL nom_echo_end got=%b want=0", echo);
        end
    endtask

    task automatic test_short;
        int e0, ecnt, bcnt;
        int widths[2] = '{3, 4};
        distance_cm  = 16'd2;
        target_valid = 1'b1;
        foreach (widths[k]) begin
            e0   = err_cnt;
            ecnt = 0;
            bcnt = 0;
            pulse_trig(widths[k]);
            repeat (30) begin
                @(negedge clk);
                if (echo) ecnt++;
                if (busy) bcnt++;
            end
            n_cmp += 3;
            if (err_cnt - e0 !== 1) begin
                n_err++;
                $display("FAIL short%0d_err got=%0d want=1", widths[k], err_cnt - e0);
            end
            if (ecnt !== 0) begin
                n_err++;
                $display("FAIL short%0d_echo got=%0d want=0", widths[k], ecnt);
            end
            if (bcnt !== 0) begin
                n_err++;
                $display("FAIL short%0d_busy got=%0d want=0", widths[k], bcnt);
            end
        end
    endtask

    task automatic test_min_trigger;
        int lat, wid, grd, exp, e0;
        logic [1:0] bz;
        e0           = err_cnt;
        distance_cm  = 16'd1;
        target_valid = 1'b1;
        exp_q.push_back(CPC);
        pulse_trig(MINT);
        measure(lat, wid, grd, bz);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp += 2;
        if (wid !== exp) begin
            n_err++;
            $display("FAIL min_trig_width got=%0d want=%0d", wid, exp);
        end
        if (err_cnt !== e0) begin
            n_err++;
            $display("FAIL min_trig_err got=%0d want=%0d", err_cnt, e0);
        end
    endtask

    task automatic test_range;
        int lat, wid, grd, exp;
        logic [1:0] bz;
        int  dists[5]  = '{9, 8, 2, 0, 65535};
        bit  valids[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int  wants[5]  = '{TMO, 8 * CPC, TMO, CPC, TMO};
        foreach (dists[k]) begin
            distance_cm  = 16'(dists[k]);
            target_valid = valids[k];
            exp_q.push_back(wants[k]);
            pulse_trig(6);
            measure(lat, wid, grd, bz);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            n_cmp++;
            if (wid !== exp) begin
                n_err++;
                $display("FAIL range_d%0d_v%0d got=%0d want=%0d",
                         dists[k], valids[k], wid, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, wid, grd, exp, i0, ecnt;
        logic [1:0] bz;
        distance_cm  = 16'd3;
        target_valid = 1'b1;
        i0 = ign_cnt;
        exp_q.push_back(3 * CPC);
        pulse_trig(6);
        fork
            measure(lat, wid, grd, bz);
            begin
                for (int i = 0; i < 50 && !echo; i++) @(negedge clk);
                repeat (3) @(negedge clk);
                pulse_trig(6);
                for (int i = 0; i < 200 && echo; i++) @(negedge clk);
                repeat (2) @(negedge clk);
                pulse_trig(6);
            end
        join
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp += 3;
        if (wid !== exp) begin
            n_err++;
            $display("FAIL retrig_width got=%0d want=%0d", wid, exp);
        end
        if (ign_cnt - i0 !== 2) begin
            n_err++;
            $display("FAIL retrig_ignored got=%0d want=2", ign_cnt - i0);
        end
        if (grd !== GRD) begin
            n_err++;
            $display("FAIL retrig_guard got=%0d want=%0d", grd, GRD);
        end
        ecnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (echo || busy) ecnt++;
        end
        n_cmp++;
        if (ecnt !== 0) begin
            n_err++;
            $display("FAIL retrig_quiet got=%0d want=0", ecnt);
        end
        distance_cm = 16'd5;
        exp_q.push_back(5 * CPC);
        pulse_trig(6);
        measure(lat, wid, grd, bz);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (wid !== exp) begin
            n_err++;
            $display("FAIL retrig_next got=%0d want=%0d", wid, exp);
        end
    endtask

    task automatic test_reset_mid;
        int lat, wid, grd, exp, seen;
        logic [1:0] bz;
        distance_cm  = 16'd3;
        target_valid = 1'b1;
        pulse_trig(6);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (echo) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (seen !== 1) begin
            n_err++;
            $display("FAIL rmid_echo_seen got=%0d want=1", seen);
        end
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (echo !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_echo got=%b want=0", echo);
        end
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_busy got=%b want=0", busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        distance_cm = 16'd1;
        exp_q.push_back(CPC);
        pulse_trig(6);
        measure(lat, wid, grd, bz);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (wid !== exp) begin
            n_err++;
            $display("FAIL rmid_after got=%0d want=%0d", wid, exp);
        end
    endtask

    task automatic test_inflight;
        int lat, wid, grd, exp;
        logic [1:0] bz;
        distance_cm  = 16'd3;
        target_valid = 1'b1;
        exp_q.push_back(3 * CPC);
        pulse_trig(6);
        fork
            measure(lat, wid, grd, bz);
            begin
                repeat (4) @(negedge clk);
                distance_cm  = 16'd7;
                target_valid = 1'b0;
            end
        join
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (wid !== exp) begin
            n_err++;
            $display("FAIL inflight_width got=%0d want=%0d", wid, exp);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        ign_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_nominal();
        test_short();
        test_min_trigger();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_inflight();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
